codeword_serializer: RTL and testbench
======================================

# codeword_serializer

Buffers 12-bit Hamming codewords from `hamming_encoder` and serializes them MSB-first into a one-bit symbol stream for the BPSK modulator. Each bit is held for a fixed number of enabled sample cycles. The block sits between the encoder and the modulator. It decouples codeword arrival rate from symbol rate through a small FIFO and emits a strobe at every symbol boundary.

## Interface
Parameters:
- `DATA_WIDTH`, 12: codeword width in bits.
- `FIFO_DEPTH`, 4: codeword buffer depth; power of two, ≥2.
- `SAMPLES_PER_SYMBOL`, 256: enabled clock cycles per transmitted bit; ≥2.

Ports:
- `clk`  in  1  single system clock.
- `arst`  in  1  reset; synchronous, active-high.
- `dv`  in  1  codeword valid, one-cycle write request.
- `data`  in  DATA_WIDTH  codeword, sampled when `dv`=1.
- `en`  in  1  sample enable; gates the symbol timer.
- `ready`  out  1  FIFO not full.
- `q`  out  1  current serial bit.
- `sym_strobe`  out  1  one-cycle pulse on the first cycle of each symbol.
- `busy`  out  1  a codeword is being shifted out.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset values: FIFO empty, `ready`=1, `q`=0, `sym_strobe`=0, `busy`=0, `overflow`=0, state IDLE, sample counter 0, bit counter 0.
- Write rules:
  - `dv`=1 with FIFO not full pushes `data`.
  - `dv`=1 with FIFO full drops the word and pulses `overflow` the next cycle.
  - A pop in the same cycle does not make room for that write.
  - `ready` = !full and is registered from FIFO occupancy.
- States:
  - IDLE: `q`=0, `busy`=0. If the FIFO is non-empty, pop the head into the shift register and go to SHIFT.
  - SHIFT: `q` = shift-register MSB, `busy`=1.
    - Sample counter advances only when `en`=1 and wraps at SAMPLES_PER_SYMBOL-1.
    - On a wrap with bit counter < DATA_WIDTH-1: shift left by one and increment the bit counter.
    - On a wrap at bit DATA_WIDTH-1 with FIFO non-empty: pop the head into the shift register directly, reset the bit counter, stay in SHIFT. There is no gap between codewords.
    - On a wrap at bit DATA_WIDTH-1 with FIFO empty: go to IDLE, drive `q`=0.
- `sym_strobe` = 1 on the first cycle of every symbol: the first cycle after a load, and the cycle after each shift.
- `en`=0 freezes the sample counter and all outputs except FIFO writes. `en` does not block loading from IDLE.
- Bit order: `data[DATA_WIDTH-1]` is transmitted first.

## Timing
- Latency from idle: `dv` at cycle t gives an entry visible at t+1, a pop and load at t+1, and `q`=bit 11 with `sym_strobe`=1 at t+2.
- Symbol duration: exactly SAMPLES_PER_SYMBOL cycles with `en`=1. One codeword occupies DATA_WIDTH×SAMPLES_PER_SYMBOL enabled cycles.
- Back-to-back codewords: bit 0 of word n occupies its last sample at cycle c. Bit 11 of word n+1 is on `q` at c+1, with `sym_strobe` at c+1.
- FIFO full and empty flags update one cycle after the push or pop.
- Reset mid-word: at the cycle after `arst` is sampled high, all outputs hold their reset values and buffered words are discarded.
- Reset with simultaneous `dv`: reset wins and the word is not stored.

## Structure
- Package `transceiver_pkg` holds:
  - `CODEWORD_WIDTH` = 12.
  - the serializer state enum (IDLE, SHIFT).
  - the default `SAMPLES_PER_SYMBOL` constant shared with `bpsk_modulator`.
- Sub-module `sync_fifo` (width DATA_WIDTH, depth FIFO_DEPTH):
  - synchronous reset.
  - `full` and `empty` flags.
  - pointers one bit wider than the address, for full/empty disambiguation.
- The top-level `codeword_serializer` holds the FSM, the sample counter, the bit counter and the shift register.

## Test plan
All scenarios use SAMPLES_PER_SYMBOL=4 and `en`=1 unless stated.
- Single word 12'hA5C written while idle -> `q` sequence 1,0,1,0,0,1,0,1,1,1,0,0, each held 4 cycles. First bit appears 2 cycles after `dv`. 12 `sym_strobe` pulses. `busy` then drops and `q`=0.
- Words 12'hFFF and 12'h000 written on consecutive cycles -> 48 cycles of `q`=1 immediately followed by 48 cycles of `q`=0. No idle cycle between words. 24 strobes.
- Six words written on consecutive cycles with FIFO_DEPTH=4 -> `ready` low after the FIFO fills. Exactly one `overflow` pulse. Only words 0–4 are transmitted, because word 0 is popped at t+1.
- `en` toggled 1,0,1,0 on every cycle during 12'h800 -> each symbol lasts 8 cycles. `q`=1 for the first 8 cycles, then 0.
- `arst` asserted mid-word (bit 5 of 12'h3C3), with two words queued -> the next cycle has `q`=0, `busy`=0, `ready`=1. No further output until a new `dv`.

Source files
------------

// File: rtl/transceiver_pkg.sv
// rtl/transceiver_pkg.sv - shared constants and state type for the transceiver datapath
package transceiver_pkg;

    localparam int CODEWORD_WIDTH             = 12;
    localparam int DEFAULT_SAMPLES_PER_SYMBOL = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-bit pointers for full/empty
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // Flags come from registered pointers, so a same-cycle pop never frees room for a write.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/codeword_serializer.sv
// rtl/codeword_serializer.sv - buffers codewords and shifts them out MSB-first as held symbols
module codeword_serializer
    import transceiver_pkg::*;
#(
    parameter int DATA_WIDTH         = CODEWORD_WIDTH,
    parameter int FIFO_DEPTH         = 4,
    parameter int SAMPLES_PER_SYMBOL = DEFAULT_SAMPLES_PER_SYMBOL
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  dv,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  en,
    output logic                  ready,
    output logic                  q,
    output logic                  sym_strobe,
    output logic                  busy,
    output logic                  overflow
);

    localparam int SW = $clog2(SAMPLES_PER_SYMBOL);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    ser_state_t            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [SW-1:0]         samp_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wrap;
    logic                  last_bit;
    logic                  pop;

    assign wrap     = en && (samp_cnt == SAMP_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    // Loading from IDLE ignores en; chaining at the end of a word happens only on the final wrap.
    assign pop      = !fifo_empty && ((state == IDLE) || (wrap && last_bit));
    assign ready    = !fifo_full;

    sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst   (arst),
        .wr_en  (dv),
        .wr_data(data),
        .rd_en  (pop),
        .rd_data(fifo_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= IDLE;
            shreg      <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            q          <= 1'b0;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow   <= dv && fifo_full;
            sym_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg      <= fifo_data;
                        q          <= fifo_data[DATA_WIDTH-1];
                        busy       <= 1'b1;
                        sym_strobe <= 1'b1;
                        samp_cnt   <= '0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end else begin
                        q    <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (wrap) begin
                        samp_cnt <= '0;
                        if (!last_bit) begin
                            shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            q          <= shreg[DATA_WIDTH-2];
                            bit_cnt    <= bit_cnt + 1'b1;
                            sym_strobe <= 1'b1;
                        end else if (!fifo_empty) begin
                            shreg      <= fifo_data;
                            q          <= fifo_data[DATA_WIDTH-1];
                            bit_cnt    <= '0;
                            sym_strobe <= 1'b1;
                        end else begin
                            q     <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (en) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codeword_serializer.sv
// tb/tb_codeword_serializer.sv - self-checking bench for codeword_serializer
module tb_codeword_serializer;

    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int SPS   = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          dv;
    logic [DW-1:0] data;
    logic          en;
    logic          ready;
    logic          q;
    logic          sym_strobe;
    logic          busy;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int n_strobe, n_qhi, n_busy, n_ovf;

    always #5 clk = ~clk;

    codeword_serializer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .SAMPLES_PER_SYMBOL(SPS)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .dv        (dv),
        .data      (data),
        .en        (en),
        .ready     (ready),
        .q         (q),
        .sym_strobe(sym_strobe),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words, the word on the line, which bit and how many
    // enabled samples of it have elapsed. Expected outputs are what the line shows next cycle.
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_cur;
    int            m_bi, m_cnt, m_sz;
    bit            m_active = 0;
    bit            chk = 0;
    logic          e_q, e_busy, e_ready, e_strobe, e_ovf;

    always @(posedge clk) begin
        if (arst) begin
            m_fifo.delete();
            m_active = 0;
            m_bi = 0;
            m_cnt = 0;
            e_q = 0; e_busy = 0; e_ready = 1; e_strobe = 0; e_ovf = 0;
            chk = 1;
        end else begin
            m_sz = m_fifo.size();
            e_ovf = dv && (m_sz == DEPTH);
            e_strobe = 0;
            if (!m_active) begin
                if (m_sz > 0) begin
                    m_cur = m_fifo.pop_front();
                    m_active = 1; m_bi = 0; m_cnt = 0; e_strobe = 1;
                end
            end else if (en) begin
                m_cnt++;
                if (m_cnt == SPS) begin
                    m_cnt = 0;
                    if (m_bi < DW - 1) begin
                        m_bi++;
                        e_strobe = 1;
                    end else if (m_sz > 0) begin
                        m_cur = m_fifo.pop_front();
                        m_bi = 0;
                        e_strobe = 1;
                    end else begin
                        m_active = 0;
                    end
                end
            end
            if (dv && m_sz < DEPTH) m_fifo.push_back(data);
            e_q = m_active ? m_cur[DW-1-m_bi] : 1'b0;
            e_busy = m_active;
            e_ready = (m_fifo.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("q", q, e_q);
            check("busy", busy, e_busy);
            check("ready", ready, e_ready);
            check("sym_strobe", sym_strobe, e_strobe);
            check("overflow", overflow, e_ovf);
            if (sym_strobe) n_strobe++;
            if (q) n_qhi++;
            if (busy) n_busy++;
            if (overflow) n_ovf++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        n_strobe = 0; n_qhi = 0; n_busy = 0; n_ovf = 0;
    endtask

    int            seq1[12] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0};
    logic [DW-1:0] words3[6] = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020};

    initial begin
        arst = 1; dv = 0; en = 1; data = '0;
        clr();
        tick(2);
        arst = 0;
        check("rst_ready", ready, 1);
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", sym_strobe, 0);
        tick(3);

        // single word, first bit two cycles after dv
        clr();
        dv = 1; data = 12'hA5C;
        tick(1);
        dv = 0;
        check("t1_latency_q", q, 0);
        tick(1);
        check("t1_first_strobe", sym_strobe, 1);
        check("t1_first_busy", busy, 1);
        for (int i = 0; i < 12; i++) begin
            check("t1_bit", q, seq1[i]);
            tick(SPS);
        end
        check("t1_done_busy", busy, 0);
        check("t1_done_q", q, 0);
        tick(5);
        check("t1_strobes", n_strobe, 12);

        // back-to-back FFF then 000, no gap
        clr();
        dv = 1; data = 12'hFFF;
        tick(1);
        data = 12'h000;
        tick(1);
        dv = 0;
        for (int i = 0; i < 96; i++) begin
            check("t2_q", q, (i < 48) ? 1 : 0);
            check("t2_busy", busy, 1);
            tick(1);
        end
        tick(4);
        check("t2_strobes", n_strobe, 24);
        check("t2_qhi", n_qhi, 48);

        // six words into a four-deep FIFO
        clr();
        for (int k = 0; k < 6; k++) begin
            dv = 1; data = words3[k];
            tick(1);
            if (k == 4) check("t3_ready_low", ready, 0);
        end
        dv = 0;
        tick(5 * 12 * SPS + 10);
        check("t3_overflows", n_ovf, 1);
        check("t3_strobes", n_strobe, 60);
        check("t3_qhi", n_qhi, 20);

        // en alternating: each symbol spans eight cycles
        clr();
        dv = 1; data = 12'h800; en = 0;
        tick(1);
        dv = 0;
        for (int i = 0; i < 110; i++) begin
            en = ~en;
            tick(1);
        end
        en = 1;
        tick(4);
        check("t4_qhi", n_qhi, 8);
        check("t4_busy", n_busy, 96);
        check("t4_strobes", n_strobe, 12);

        // reset in the middle of a word with two more queued
        clr();
        dv = 1; data = 12'h3C3;
        tick(1);
        data = 12'h0F0;
        tick(1);
        data = 12'hF0F;
        tick(1);
        dv = 0;
        tick(20);
        check("t5_busy_before", busy, 1);
        arst = 1;
        tick(1);
        arst = 0;
        check("t5_q", q, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", ready, 1);
        clr();
        tick(100);
        check("t5_quiet_strobes", n_strobe, 0);
        check("t5_quiet_busy", n_busy, 0);

        // reset beats a simultaneous write
        arst = 1; dv = 1; data = 12'hFFF;
        tick(1);
        arst = 0; dv = 0;
        clr();
        tick(20);
        check("t6_busy", n_busy, 0);
        check("t6_ready", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
